seq_mux: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer with an enable, a valid/ready output handshake and an optional round-robin scan mode. It is the clocked, generalised successor to the team's 16:1 single-bit combinational mux benchmark. It sits between a bank of parallel data sources and a single downstream consumer that may apply backpressure.

---
 rtl/seq_mux.sv | 73 +++++++
 tb/tb_seq_mux.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_mux.sv
// Registered N-channel, W-bit multiplexer with a valid/ready output handshake.
// Define SEQ_MUX_SCAN_EN to enable round-robin scan mode (scan port and ptr).
module seq_mux #(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned WIDTH    = 1,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      en,
  input  logic                      scan,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan
);

  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

  logic             load_c;
  logic [SEL_W-1:0] chan_c;
  logic [WIDTH-1:0] data_c;

  // A new sample may enter when the register is empty or being drained.
  assign load_c = en & (~out_valid | out_ready);

`ifdef SEQ_MUX_SCAN_EN
  logic [SEL_W-1:0] ptr;

  assign chan_c = scan ? ptr : sel;

  // Round-robin pointer wraps at CHANNELS, so it never goes out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load_c && scan) begin
      ptr <= (ptr == LAST_CHAN) ? '0 : ptr + SEL_W'(1);
    end
  end
`else
  logic scan_unused_c;

  assign scan_unused_c = scan;
  assign chan_c        = sel;
`endif

  // Out-of-range channel indices select all zeros.
  always_comb begin
    data_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (chan_c == SEL_W'(i)) begin
        data_c = din[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_c) begin
      out_valid <= 1'b1;
      out_data  <= data_c;
      out_chan  <= chan_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_mux.sv
// Directed self-checking bench for seq_mux: a 16x8 instance for direct-mode
// and handshake behaviour, a 5x8 instance for out-of-range and scan behaviour.
module tb_seq_mux;

  logic clk;
  logic rst;

  logic [16*8-1:0] din_a;
  logic [3:0]      sel_a;
  logic            en_a, scan_a, ready_a;
  logic            valid_a;
  logic [7:0]      data_a;
  logic [3:0]      chan_a;

  logic [5*8-1:0]  din_b;
  logic [2:0]      sel_b;
  logic            en_b, scan_b, ready_b;
  logic            valid_b;
  logic [7:0]      data_b;
  logic [2:0]      chan_b;

  int checks   = 0;
  int failures = 0;

  seq_mux #(.CHANNELS(16), .WIDTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .din(din_a), .sel(sel_a), .en(en_a), .scan(scan_a),
    .out_ready(ready_a), .out_valid(valid_a), .out_data(data_a), .out_chan(chan_a)
  );

  seq_mux #(.CHANNELS(5), .WIDTH(8)) u_dut_b (
    .clk(clk), .rst(rst), .din(din_b), .sel(sel_b), .en(en_b), .scan(scan_b),
    .out_ready(ready_b), .out_valid(valid_b), .out_data(data_b), .out_chan(chan_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) din_a[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++)  din_b[i*8 +: 8] = 8'(8'hA0 + i);
    rst = 1'b1;
    sel_a = '0; en_a = 1'b0; scan_a = 1'b0; ready_a = 1'b0;
    sel_b = '0; en_b = 1'b0; scan_b = 1'b0; ready_b = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_data_a",  32'(data_a),  0);
    check("rst_chan_a",  32'(chan_a),  0);
    check("rst_valid_b", 32'(valid_b), 0);
    check("rst_data_b",  32'(data_b),  0);
    check("rst_chan_b",  32'(chan_b),  0);

    // Direct select
    sel_a = 4'd5; en_a = 1'b1; ready_a = 1'b1;
    step();
    check("dir_valid", 32'(valid_a), 1);
    check("dir_data",  32'(data_a),  32'h15);
    check("dir_chan",  32'(chan_a),  5);

    // Backpressure: capture ch3, stall 4 cycles while sel moves to 9
    sel_a = 4'd3;
    step();
    check("bp_cap_data", 32'(data_a), 32'h13);
    ready_a = 1'b0; sel_a = 4'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", 32'(valid_a), 1);
      check("bp_hold_data",  32'(data_a),  32'h13);
      check("bp_hold_chan",  32'(chan_a),  3);
    end
    ready_a = 1'b1;
    step();
    check("bp_rel_data", 32'(data_a), 32'h19);
    check("bp_rel_chan", 32'(chan_a), 9);

    // en gating: sample drains, data holds
    en_a = 1'b0;
    step();
    check("eng_valid", 32'(valid_a), 0);
    check("eng_data",  32'(data_a),  32'h19);
    check("eng_chan",  32'(chan_a),  9);
    step();
    check("rdy_no_valid", 32'(valid_a), 0);

    // Full throughput with boundary channels
    en_a = 1'b1; sel_a = 4'd0;
    step();
    check("tp_ch0", 32'(data_a), 32'h10);
    sel_a = 4'd15;
    step();
    check("tp_ch15_valid", 32'(valid_a), 1);
    check("tp_ch15_data",  32'(data_a),  32'h1F);
    check("tp_ch15_chan",  32'(chan_a),  15);

    // Out-of-range select on 5 channels
    sel_b = 3'd6; en_b = 1'b1; ready_b = 1'b1;
    step();
    check("oor6_valid", 32'(valid_b), 1);
    check("oor6_data",  32'(data_b),  0);
    check("oor6_chan",  32'(chan_b),  6);
    sel_b = 3'd7;
    step();
    check("oor7_data", 32'(data_b), 0);
    check("oor7_chan", 32'(chan_b), 7);
    sel_b = 3'd4;
    step();
    check("last_ch_data", 32'(data_b), 32'hA4);

`ifdef SEQ_MUX_SCAN_EN
    // Scan wrap at 5
    scan_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("scan_chan", 32'(chan_b), 32'(i % 5));
      check("scan_data", 32'(data_b), 32'(8'hA0 + (i % 5)));
    end
    step();
    check("scan_pre_rst", 32'(chan_b), 2);
    // ptr is now 3 with a valid sample pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("scan_rst_valid", 32'(valid_b), 0);
    check("scan_rst_data",  32'(data_b),  0);
    check("scan_rst_chan",  32'(chan_b),  0);
    step();
    check("scan_post_rst_chan", 32'(chan_b), 0);
    check("scan_post_rst_data", 32'(data_b), 32'hA0);
    en_b = 1'b0;
    step();
    check("scan_eng_valid", 32'(valid_b), 0);
    check("scan_eng_data",  32'(data_b),  32'hA0);
    step();
    en_b = 1'b1;
    step();
    check("scan_ptr_held", 32'(chan_b), 1);
    scan_b = 1'b0; sel_b = 3'd4;
    step();
    check("mode_direct", 32'(chan_b), 4);
    scan_b = 1'b1;
    step();
    check("mode_resume", 32'(chan_b), 2);
`else
    // Scan port ignored in this build
    scan_b = 1'b1; sel_b = 3'd2;
    step();
    check("noscan_chan", 32'(chan_b), 2);
    check("noscan_data", 32'(data_b), 32'hA2);
    step();
    check("noscan_hold_chan", 32'(chan_b), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("noscan_rst_valid", 32'(valid_b), 0);
    check("noscan_rst_data",  32'(data_b),  0);
    check("noscan_rst_chan",  32'(chan_b),  0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
